// File: rtl/as_pkg.sv
// as_pkg: shared opcodes, FSM states, instruction field positions and EXEC control word
package as_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADDI  = 4'h1,
        OP_ADD   = 4'h2,
        OP_LDACC = 4'h3,
        OP_MACC  = 4'h4,
        OP_IN    = 4'h5,
        OP_BZ    = 4'h6,
        OP_BNZ   = 4'h7,
        OP_JMP   = 4'h8,
        OP_TSW   = 4'h9,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_e;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic add_a_sel;
        logic add_b_sel;
        logic acc_en;
        logic acc_add;
        logic in_en;
        logic reg_we;
        logic z_cap;
        logic br_z;
        logic br_nz;
        logic jmp;
        logic halt;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/as_decode.sv
// as_decode: purely combinational opcode to EXEC control-word mapping
module as_decode
    import as_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    // unlisted opcodes (A-E) behave as NOP but raise the illegal marker
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_NOP:   ctrl.z_cap = 1'b0;
            OP_ADDI:  begin ctrl.add_b_sel = 1'b1; ctrl.reg_we = 1'b1; ctrl.z_cap = 1'b1; end
            OP_ADD:   begin ctrl.reg_we = 1'b1; ctrl.z_cap = 1'b1; end
            OP_LDACC: begin ctrl.add_b_sel = 1'b1; ctrl.acc_en = 1'b1; ctrl.z_cap = 1'b1; end
            OP_MACC:  begin ctrl.acc_add = 1'b1; ctrl.acc_en = 1'b1; ctrl.z_cap = 1'b1; end
            OP_IN:    begin ctrl.in_en = 1'b1; ctrl.reg_we = 1'b1; end
            OP_BZ:    ctrl.br_z = 1'b1;
            OP_BNZ:   ctrl.br_nz = 1'b1;
            OP_JMP:   ctrl.jmp = 1'b1;
            OP_TSW:   begin ctrl.add_a_sel = 1'b1; ctrl.z_cap = 1'b1; end
            OP_HALT:  ctrl.halt = 1'b1;
            default:  ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/as_ctrl.sv
// as_ctrl: three-phase fetch/decode/exec sequencer holding PC, IR, zero flag and sticky illegal flag
module as_ctrl
    import as_pkg::*;
#(
    parameter int n   = 8,
    parameter int PCW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [15:0]    instr,
    input  logic           z,
    output logic [PCW-1:0] pc,
    output logic [1:0]     rd_addr,
    output logic [1:0]     rs_addr,
    output logic [n-1:0]   immediate,
    output logic           add_a_sel,
    output logic           add_b_sel,
    output logic           acc_en,
    output logic           acc_add,
    output logic           in_en,
    output logic           reg_we,
    output logic           halted,
    output logic           illegal
);

    state_e         state;
    state_e         state_nxt;
    logic [15:0]    ir;
    logic           z_flag;
    logic [PCW-1:0] pc_nxt;
    ctrl_t          ctrl;
    logic           exec_on;
    logic           take;
    logic [n+7:0]   imm_ext;
    logic [PCW+7:0] pc_imm_ext;

    as_decode u_decode (
        .opcode (ir[OP_HI:OP_LO]),
        .ctrl   (ctrl)
    );

    assign imm_ext    = {{n{1'b0}}, ir[IMM_HI:IMM_LO]};
    assign pc_imm_ext = {{PCW{1'b0}}, ir[IMM_HI:IMM_LO]};
    assign immediate  = imm_ext[n-1:0];
    assign rd_addr    = ir[RD_HI:RD_LO];
    assign rs_addr    = ir[RS_HI:RS_LO];

    // branches look at the flag captured by an earlier EXEC, never the live z
    assign take    = ctrl.jmp | (ctrl.br_z & z_flag) | (ctrl.br_nz & ~z_flag);
    assign exec_on = en & (state == EXEC);

    assign add_a_sel = exec_on & ctrl.add_a_sel;
    assign add_b_sel = exec_on & ctrl.add_b_sel;
    assign acc_en    = exec_on & ctrl.acc_en;
    assign acc_add   = exec_on & ctrl.acc_add;
    assign in_en     = exec_on & ctrl.in_en;
    assign reg_we    = exec_on & ctrl.reg_we;
    assign halted    = (state == HALT);

    // next state and next pc; pc only moves at the end of EXEC
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                state_nxt = ctrl.halt ? HALT : FETCH;
                pc_nxt    = ctrl.halt ? pc : take ? pc_imm_ext[PCW-1:0] : pc + PCW'(1);
            end
            default: state_nxt = HALT;
        endcase
    end

    // architectural state; everything freezes while en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            z_flag  <= 1'b0;
            illegal <= 1'b0;
        end else if (en) begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == DECODE) ir <= instr;
            if (state == EXEC && ctrl.z_cap) z_flag <= z;
            if (state == EXEC && ctrl.illegal) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_as_ctrl.sv
// tb_as_ctrl: directed scenario tests for the as_ctrl sequencer
module tb_as_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        z = 1'b0;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic [1:0]  rd_addr, rs_addr;
    logic [7:0]  immediate;
    logic        add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we, halted, illegal;
    logic [5:0]  ctl;
    logic [15:0] mem [256];
    int          errors = 0;
    int          checks = 0;

    as_ctrl #(.n(8), .PCW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .instr     (instr),
        .z         (z),
        .pc        (pc),
        .rd_addr   (rd_addr),
        .rs_addr   (rs_addr),
        .immediate (immediate),
        .add_a_sel (add_a_sel),
        .add_b_sel (add_b_sel),
        .acc_en    (acc_en),
        .acc_add   (acc_add),
        .in_en     (in_en),
        .reg_we    (reg_we),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // synchronous program memory: data valid one cycle after the address
    always @(posedge clk) instr <= mem[pc];

    assign ctl = {add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we};

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic start();
        reset = 1'b1;
        en = 1'b1;
        z = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        step(2);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", pc); end
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b want 000000", ctl); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {halted, illegal}); end
        checks++; if (immediate !== 8'h00) begin errors++; $display("FAIL reset_imm got %h want 00", immediate); end
        reset = 1'b0;
        step(1);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL first_fetch_pc got %h want 00", pc); end
    endtask

    task automatic test_addi();
        clear_mem();
        mem[0] = 16'h1306;
        start();
        step(1);
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL addi_decode_ctl got %b want 000000", ctl); end
        step(1);
        checks++; if (ctl !== 6'b010001) begin errors++; $display("FAIL addi_exec_ctl got %b want 010001", ctl); end
        checks++; if (immediate !== 8'h06) begin errors++; $display("FAIL addi_imm got %h want 06", immediate); end
        checks++; if ({rd_addr, rs_addr} !== 4'b0011) begin errors++; $display("FAIL addi_regs got %b want 0011", {rd_addr, rs_addr}); end
        step(1);
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL addi_pc got %h want 01", pc); end
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL addi_fetch_ctl got %b want 000000", ctl); end
    endtask

    task automatic test_decode();
        logic [5:0] exp_c [4];
        logic [1:0] exp_rd [4];
        clear_mem();
        mem[0] = 16'h3400; exp_c[0] = 6'b011000; exp_rd[0] = 2'd1;
        mem[1] = 16'h5800; exp_c[1] = 6'b000011; exp_rd[1] = 2'd2;
        mem[2] = 16'h9000; exp_c[2] = 6'b100000; exp_rd[2] = 2'd0;
        mem[3] = 16'h2C00; exp_c[3] = 6'b000001; exp_rd[3] = 2'd3;
        start();
        for (int i = 0; i < 4; i++) begin
            step(2);
            checks++; if (ctl !== exp_c[i]) begin errors++; $display("FAIL decode_ctl[%0d] got %b want %b", i, ctl, exp_c[i]); end
            checks++; if (rd_addr !== exp_rd[i]) begin errors++; $display("FAIL decode_rd[%0d] got %0d want %0d", i, rd_addr, exp_rd[i]); end
            step(1);
        end
        checks++; if (pc !== 8'h04) begin errors++; $display("FAIL decode_pc got %h want 04", pc); end
    endtask

    task automatic test_branch();
        clear_mem();
        mem[8'h00] = 16'h4000;
        mem[8'h01] = 16'h6020;
        mem[8'h20] = 16'h4000;
        mem[8'h21] = 16'h6040;
        mem[8'h22] = 16'h7030;
        start();
        z = 1'b1;
        step(2);
        checks++; if (ctl !== 6'b001100) begin errors++; $display("FAIL macc_ctl got %b want 001100", ctl); end
        step(1);
        z = 1'b0;
        step(3);
        checks++; if (pc !== 8'h20) begin errors++; $display("FAIL bz_taken_pc got %h want 20", pc); end
        z = 1'b0;
        step(3);
        z = 1'b1;
        step(3);
        checks++; if (pc !== 8'h22) begin errors++; $display("FAIL bz_not_taken_pc got %h want 22", pc); end
        z = 1'b0;
        step(3);
        checks++; if (pc !== 8'h30) begin errors++; $display("FAIL bnz_taken_pc got %h want 30", pc); end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem[8'h00] = 16'h80FF;
        mem[8'hFF] = 16'h0000;
        start();
        step(3);
        checks++; if (pc !== 8'hFF) begin errors++; $display("FAIL jmp_pc got %h want ff", pc); end
        step(3);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h want 00", pc); end
    endtask

    task automatic test_enable();
        clear_mem();
        mem[0] = 16'h1306;
        start();
        step(1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if ({pc, immediate, ctl} !== {8'h00, 8'h00, 6'b0}) begin errors++; $display("FAIL en_hold[%0d] got pc=%h imm=%h ctl=%b want pc=00 imm=00 ctl=000000", i, pc, immediate, ctl); end
        end
        en = 1'b1;
        step(1);
        checks++; if ({ctl, immediate} !== {6'b010001, 8'h06}) begin errors++; $display("FAIL en_resume got ctl=%b imm=%h want ctl=010001 imm=06", ctl, immediate); end
        en = 1'b0;
        #1;
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL en_low_exec_ctl got %b want 000000", ctl); end
        step(2);
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL en_low_exec_pc got %h want 00", pc); end
        en = 1'b1;
        step(1);
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL en_resume_pc got %h want 01", pc); end
    endtask

    task automatic test_illegal_halt();
        clear_mem();
        mem[0] = 16'hB000;
        mem[1] = 16'hF000;
        start();
        step(2);
        checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL illegal_ctl got %b want 000000", ctl); end
        step(1);
        checks++; if ({illegal, pc} !== {1'b1, 8'h01}) begin errors++; $display("FAIL illegal_set got illegal=%b pc=%h want illegal=1 pc=01", illegal, pc); end
        step(2);
        checks++; if ({halted, ctl} !== {1'b0, 6'b0}) begin errors++; $display("FAIL halt_exec got halted=%b ctl=%b want halted=0 ctl=000000", halted, ctl); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++; if ({halted, pc, ctl} !== {1'b1, 8'h01, 6'b0}) begin errors++; $display("FAIL halt_hold[%0d] got halted=%b pc=%h ctl=%b want halted=1 pc=01 ctl=000000", i, halted, pc, ctl); end
        end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b want 1", illegal); end
    endtask

    task automatic test_reset_exec();
        clear_mem();
        mem[0] = 16'hA000;
        mem[1] = 16'h2400;
        start();
        step(3);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL rexec_illegal got %b want 1", illegal); end
        step(2);
        checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL rexec_we_before got %b want 1", reg_we); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({reg_we, acc_en, pc, illegal, halted} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL rexec_async got we=%b acc=%b pc=%h ill=%b hlt=%b want we=0 acc=0 pc=00 ill=0 hlt=0", reg_we, acc_en, pc, illegal, halted); end
        step(2);
        reset = 1'b0;
        step(3);
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL rexec_restart_pc got %h want 01", pc); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_decode();
        test_branch();
        test_wrap();
        test_enable();
        test_illegal_halt();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/as_ctrl.md
AS_CTRL -- requirements
Module: as_ctrl

Interface
REQ-001 SHALL have parameter n, default 8: data width of the immediate output and of the downstream ALU.
REQ-002 SHALL have parameter PCW, default 8: program counter width.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; when low the FSM and PC SHALL hold their values.
REQ-006 instr  input  16  instruction word from program memory; valid one cycle after pc is presented.
REQ-007 z  input  1  zero flag from ALU, for the current EXEC cycle.
REQ-008 pc  output  PCW  program memory address.
REQ-009 rd_addr, rs_addr  output  2 each  register file read addresses; rd_addr is also the write address.
REQ-010 immediate  output  n  instr[7:0], zero-extended or truncated to n.
REQ-011 add_a_sel, add_b_sel, acc_en, acc_add, in_en  output  1 each  ALU datapath controls.
REQ-012 reg_we  output  1  register file write enable.
REQ-013 halted  output  1  high while in HALT.
REQ-014 illegal  output  1  sticky flag, set by an undefined opcode.

Function
REQ-015 Instruction fields SHALL be: opcode = instr[15:12], rd = instr[11:10], rs = instr[9:8], imm = instr[7:0].
REQ-016 FSM states SHALL be FETCH -> DECODE -> EXEC -> FETCH, plus HALT; each state lasts one en-qualified cycle, so one instruction takes 3 cycles.
REQ-017 FETCH: pc is presented; no control asserted.
REQ-018 DECODE: instr SHALL be latched into the instruction register (IR); no control asserted.
REQ-019 EXEC: controls SHALL be driven from the IR for exactly one cycle; rd_addr, rs_addr and immediate SHALL come from the IR in DECODE and EXEC.
REQ-020 Opcodes and their EXEC controls (unlisted controls are 0):
- 0 NOP: none.
- 1 ADDI: add_b_sel, reg_we.
- 2 ADD: reg_we.
- 3 LDACC: add_b_sel, acc_en.
- 4 MACC: acc_add, acc_en.
- 5 IN: in_en, reg_we.
- 6 BZ, 7 BNZ, 8 JMP: none.
- 9 TSW: add_a_sel.
- F HALT: none.
REQ-021 Register z_flag SHALL capture z at the end of EXEC for ADDI, ADD, LDACC, MACC and TSW, and SHALL be unchanged otherwise.
REQ-022 PC SHALL update at the end of EXEC:
- JMP: pc <= imm.
- BZ: pc <= imm if z_flag = 1, else pc+1.
- BNZ: pc <= imm if z_flag = 0, else pc+1.
- All other opcodes: pc+1.
- Increment SHALL wrap modulo 2^PCW.
REQ-023 Branch conditions SHALL use z_flag as held before that EXEC, not the live z.
REQ-024 HALT in EXEC SHALL enter HALT: pc is held, halted = 1, controls 0. HALT SHALL be left only by reset.
REQ-025 Opcodes A-E SHALL execute as NOP, advance pc by 1 and set illegal; illegal SHALL clear only on reset.
REQ-026 When en is low in any state, all controls and reg_we SHALL be 0 and nothing SHALL update; when en rises the FSM SHALL resume in the same state.

Reset
REQ-027 Reset SHALL act asynchronously: state = FETCH, pc = 0, IR = 0, z_flag = 0, illegal = 0, halted = 0, and all control outputs = 0.
REQ-028 Reset during EXEC SHALL suppress that cycle's reg_we and acc_en at once; no write or pc update SHALL survive.
REQ-029 After reset is released, the first FETCH SHALL present pc = 0 on the next rising edge.

Structure
REQ-030 Package as_pkg SHALL hold: opcode enum (4-bit), FSM state enum, instruction field positions, and a control-word struct.
REQ-031 Combinational sub-module as_decode SHALL map opcode to the control-word struct; as_ctrl SHALL hold the FSM, PC, IR and flags.

Verification
REQ-032 Reset, then instr = 0x1306 (ADDI r0, 6) -> in cycle 3: add_b_sel = 1, reg_we = 1, immediate = 6; then pc = 1.
REQ-033 MACC then BZ 0x20 with z = 1 during the MACC EXEC -> pc = 0x20 after BZ EXEC; repeat with z = 0 -> pc = previous + 1.
REQ-034 pc = 0xFF executing NOP -> pc = 0x00.
REQ-035 Drop en for 4 cycles mid-DECODE -> state, pc and IR held with controls 0; resume -> EXEC occurs on the next enabled cycle.
REQ-036 Opcode 0xB -> illegal = 1, pc advances; then HALT (0xF000) -> halted = 1, pc frozen over 10 cycles.
REQ-037 Assert reset in the ADD EXEC cycle -> reg_we drops the same cycle, pc = 0, illegal = 0.
